// File: rtl/data_buffer_wrapper_if.sv
// Producer/consumer bus between the word producers, the buffer and the display path.
// The master drives writes, ticks and flush. The slave (the buffer) returns data and status.
interface data_buffer_wrapper_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic             data_1_en;
    logic [WIDTH-1:0] data_1;
    logic             rd_tick;
    logic             flush;
    logic [WIDTH-1:0] data_2;
    logic             data_2_valid;
    logic             buffer_full;
    logic             buffer_empty;
    logic [AW:0]      count;
    logic             overflow;

    modport master (
        output data_1_en, data_1, rd_tick, flush,
        input  data_2, data_2_valid, buffer_full, buffer_empty, count, overflow
    );

    modport slave (
        input  data_1_en, data_1, rd_tick, flush,
        output data_2, data_2_valid, buffer_full, buffer_empty, count, overflow
    );
endinterface

// File: rtl/data_buffer_wrapper.sv
// Circular FIFO that takes producer words and releases one word per slow tick.
// Full and empty come from the stored-word count only and never from comparing pointers.
module data_buffer_wrapper #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst,
    data_buffer_wrapper_if.slave bus
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] data_2_q, data_2_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             full, empty, wr_en, pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    // Flush outranks both a write and a pop in the same cycle.
    assign wr_en = bus.data_1_en && !full && !bus.flush;
    assign pop   = bus.rd_tick && !empty && !bus.flush;

    // NOTE: every next-state signal gets its default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_2_d = data_2_q;
        valid_d  = valid_q;
        ovf_d    = 1'b0;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
        end else begin
            ovf_d = bus.data_1_en && full;
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (bus.rd_tick) begin
                if (pop) begin
                    data_2_d = mem_q[rd_ptr_q];
                    valid_d  = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end else begin
                    // The displayed word is consumed and nothing replaces it.
                    valid_d = 1'b0;
                end
            end
            case ({wr_en, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_2_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_2_q <= data_2_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: storage has no reset because count gates every read, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= bus.data_1;
    end

    assign bus.data_2       = data_2_q;
    assign bus.data_2_valid = valid_q;
    assign bus.buffer_full  = full;
    assign bus.buffer_empty = empty;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_data_buffer_wrapper.sv
// Bench for data_buffer_wrapper. A queue model is compared with the DUT on every falling edge.
// Directed steps add hand-computed literal expectations.
module tb_data_buffer_wrapper;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    data_buffer_wrapper_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    data_buffer_wrapper #(.DEPTH(DEPTH), .AW(AW), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: stored words live in a queue, and the displayed word is separate state.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_d2  = '0;
    logic             m_v   = 1'b0;
    logic             m_ovf = 1'b0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            q.delete(); m_d2 = '0; m_v = 1'b0; m_ovf = 1'b0;
        end else if (bus.flush) begin
            q.delete(); m_v = 1'b0; m_ovf = 1'b0;
        end else begin
            automatic bit was_full  = (q.size() == DEPTH);
            automatic bit was_empty = (q.size() == 0);
            m_ovf = bus.data_1_en && was_full;
            if (bus.rd_tick) begin
                if (!was_empty) begin m_d2 = q.pop_front(); m_v = 1'b1; end
                else m_v = 1'b0;
            end
            if (bus.data_1_en && !was_full) q.push_back(bus.data_1);
        end
    end

    always @(negedge clk) begin
        check("count",  32'(bus.count),        32'(q.size()));
        check("full",   32'(bus.buffer_full),  32'(q.size() == DEPTH));
        check("empty",  32'(bus.buffer_empty), 32'(q.size() == 0));
        check("valid",  32'(bus.data_2_valid), 32'(m_v));
        check("data_2", 32'(bus.data_2),       32'(m_d2));
        check("ovf",    32'(bus.overflow),     32'(m_ovf));
    end

    // Applies one cycle of inputs, returns 1 ns after the edge, and leaves the inputs idle.
    task automatic drive(input logic en, input logic [WIDTH-1:0] d, input logic tick, input logic fl);
        bus.data_1_en = en; bus.data_1 = d; bus.rd_tick = tick; bus.flush = fl;
        @(posedge clk); #1;
        bus.data_1_en = 1'b0; bus.rd_tick = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        bus.data_1_en = 1'b0; bus.data_1 = '0; bus.rd_tick = 1'b0; bus.flush = 1'b0;
        #12;
        check("rst_count", 32'(bus.count), 0);
        check("rst_empty", 32'(bus.buffer_empty), 1);
        check("rst_full",  32'(bus.buffer_full), 0);
        check("rst_valid", 32'(bus.data_2_valid), 0);
        @(posedge clk); #1; rst = 1'b0;

        // Reset mid-stream.
        drive(1, 16'h000A, 0, 0); drive(1, 16'h000B, 0, 0); drive(1, 16'h000C, 0, 0);
        drive(0, 0, 1, 0);
        check("pre_rst_d2", 32'(bus.data_2), 32'h000A);
        rst = 1'b1; @(posedge clk); #1;
        check("midrst_count", 32'(bus.count), 0);
        check("midrst_empty", 32'(bus.buffer_empty), 1);
        check("midrst_valid", 32'(bus.data_2_valid), 0);
        check("midrst_d2",    32'(bus.data_2), 0);
        rst = 1'b0; @(posedge clk); #1;
        drive(1, 16'h0005, 0, 0); drive(0, 0, 1, 0);
        check("post_rst_d2", 32'(bus.data_2), 32'h0005);
        drive(0, 0, 1, 0);
        check("post_rst_valid", 32'(bus.data_2_valid), 0);

        // Fill to full, then overflow.
        for (int i = 1; i <= 8; i++) drive(1, 16'(i), 0, 0);
        check("fill_count", 32'(bus.count), 8);
        check("fill_full",  32'(bus.buffer_full), 1);
        drive(1, 16'h0009, 0, 0);
        check("ovf_pulse", 32'(bus.overflow), 1);
        check("ovf_count", 32'(bus.count), 8);
        idle(1);
        check("ovf_clear", 32'(bus.overflow), 0);

        // Drain with spaced ticks, then check order across the pointer wrap.
        for (int i = 1; i <= 8; i++) begin
            drive(0, 0, 1, 0);
            check("drain_d2", 32'(bus.data_2), 32'(i));
            check("drain_valid", 32'(bus.data_2_valid), 1);
            idle(9);
        end
        check("drain_empty", 32'(bus.buffer_empty), 1);
        for (int i = 0; i < 5; i++) drive(1, 16'(16'h0010 + i), 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0);
            check("wrap_d2", 32'(bus.data_2), 32'(16'h0010 + i));
        end
        drive(0, 0, 1, 0);

        // Drain to idle with two stored words.
        drive(1, 16'h0021, 0, 0); drive(1, 16'h0022, 0, 0);
        drive(0, 0, 1, 0);
        check("idle_v1", 32'(bus.data_2_valid), 1);
        drive(0, 0, 1, 0);
        check("idle_v2", 32'(bus.data_2_valid), 1);
        drive(0, 0, 1, 0);
        check("idle_v3", 32'(bus.data_2_valid), 0);
        check("idle_empty", 32'(bus.buffer_empty), 1);
        check("idle_d2", 32'(bus.data_2), 32'h0022);

        // Simultaneous write and pop at count=4.
        for (int i = 1; i <= 4; i++) drive(1, 16'(16'h0030 + i), 0, 0);
        drive(1, 16'h0035, 1, 0);
        check("sim4_count", 32'(bus.count), 4);
        check("sim4_d2", 32'(bus.data_2), 32'h0031);
        for (int i = 2; i <= 5; i++) begin
            drive(0, 0, 1, 0);
            check("sim4_order", 32'(bus.data_2), 32'(16'h0030 + i));
        end
        drive(0, 0, 1, 0);

        // Simultaneous write and pop at count=0: no bypass.
        drive(1, 16'h0040, 1, 0);
        check("sim0_count", 32'(bus.count), 1);
        check("sim0_valid", 32'(bus.data_2_valid), 0);

        // Simultaneous write and pop at count=8: pop happens, write dropped.
        for (int i = 1; i <= 7; i++) drive(1, 16'(16'h0040 + i), 0, 0);
        check("sim8_full", 32'(bus.buffer_full), 1);
        drive(1, 16'h0099, 1, 0);
        check("sim8_ovf", 32'(bus.overflow), 1);
        check("sim8_count", 32'(bus.count), 7);
        check("sim8_d2", 32'(bus.data_2), 32'h0040);
        for (int i = 1; i <= 7; i++) begin
            drive(0, 0, 1, 0);
            check("sim8_order", 32'(bus.data_2), 32'(16'h0040 + i));
        end
        drive(0, 0, 1, 0);

        // Flush against a concurrent write and pop.
        for (int i = 1; i <= 6; i++) drive(1, 16'(16'h0050 + i), 0, 0);
        drive(0, 0, 1, 0);
        check("pre_flush_count", 32'(bus.count), 5);
        drive(1, 16'h0077, 1, 1);
        check("flush_count", 32'(bus.count), 0);
        check("flush_valid", 32'(bus.data_2_valid), 0);
        check("flush_d2", 32'(bus.data_2), 32'h0051);
        drive(1, 16'h0055, 0, 0); drive(0, 0, 1, 0);
        check("post_flush_d2", 32'(bus.data_2), 32'h0055);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/data_buffer_wrapper.md
Name: data_buffer_wrapper

Overview:
- Buffer and consumer side of the producer/consumer datapath.
- Accepts 16-bit words from the Fibonacci or Timer producer through a write strobe, and stores them in a circular FIFO.
- Releases one word per slow-clock tick to the display path as data_2/data_2_valid.
- Exports buffer_full, buffer_empty and data_2_valid, which the top-level control FSM uses to pause production, resume it, and return to idle.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- AW, 3, pointer width; log2(DEPTH).
- WIDTH, 16, data word width.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- data_1_en  in  1  write strobe from producer; one word per cycle high.
- data_1  in  WIDTH  write data, sampled when data_1_en=1.
- rd_tick  in  1  one-clk-wide pulse at the slow consume rate (clk_2 edge, already synchronised to clk).
- flush  in  1  synchronous clear of FIFO contents and output register.
- data_2  out  WIDTH  word currently presented to the display.
- data_2_valid  out  1  data_2 holds an unconsumed word.
- buffer_full  out  1  count==DEPTH.
- buffer_empty  out  1  count==0.
- count  out  AW+1  number of stored words, 0..DEPTH.
- overflow  out  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, data_2=0, data_2_valid=0, overflow=0. Outputs therefore read buffer_empty=1, buffer_full=0. Memory contents are don't-care.
- All state is clocked on posedge clk. Reset asserted mid-operation discards stored words immediately, with no partial writes.
- buffer_full and buffer_empty are combinational decodes of the registered count, so they are valid in the same cycle count changes.
- Write condition: data_1_en=1 and buffer_full=0 at the clock edge.
  - Effects: mem[wr_ptr]<=data_1; wr_ptr<=wr_ptr+1, wrapping modulo DEPTH.
- Write while full: data_1_en=1 and buffer_full=0 is false.
  - The word is dropped.
  - overflow=1 for exactly that cycle.
  - Pointers are unchanged.
  - This applies even if a pop occurs in the same cycle, because full is evaluated on the pre-edge count.
- Pop condition: rd_tick=1 and buffer_empty=0.
  - Effects: data_2<=mem[rd_ptr]; data_2_valid<=1; rd_ptr<=rd_ptr+1, wrapping.
  - data_2 updates one clk after the rd_tick edge. There is no other read latency.
- rd_tick=1 while empty: data_2_valid<=0 and data_2 holds its last value. The displayed word is consumed and nothing replaces it.
- rd_tick=0: data_2 and data_2_valid hold.
- Count update:
  - +1 on an accepted write only.
  - −1 on a pop only.
  - Unchanged when both occur in the same cycle. Simultaneous write and pop at count in 1..DEPTH-1 are both performed.
  - Simultaneous write and pop at count=0: the pop is not performed because the FIFO is empty, and the write is performed. A word never bypasses the FIFO, so data_2_valid<=0 in that cycle.
- flush=1: pointers, count, data_2_valid and overflow all clear to 0 at the next edge. flush has priority over writes and pops in the same cycle. data_2 holds its value.
- Drain-complete condition seen by the control FSM: buffer_empty=1 and data_2_valid=0. This is reached one rd_tick after the last word is popped.
- Ordering: words leave strictly in write order.
- Pointer wrap: the pointers are AW bits wide and wrap silently. Full/empty status comes only from count, never from pointer comparison.

Test Plan:
- Reset behaviour: assert rst mid-stream after 3 writes -> next cycle count=0, buffer_empty=1, data_2_valid=0, data_2=0. Then 1 write of 0x0005 plus 1 rd_tick -> data_2=0x0005.
- Fill to full: write 0x0001..0x0008 on consecutive cycles with no rd_tick -> count=8, buffer_full=1. A 9th write of 0x0009 -> overflow pulses once, count stays 8.
- Wrap-around and order: after the fill, issue 8 rd_ticks spaced 10 clk apart -> data_2 steps 0x0001..0x0008. Write 0x0010..0x0014 and pop all -> order preserved across pointer wrap.
- Drain to idle: with 2 words stored, apply 3 rd_ticks -> valid=1 after ticks 1 and 2. After tick 3, data_2_valid=0 and buffer_empty=1, and data_2 keeps the second word.
- Simultaneous events:
  - count=4, write plus rd_tick in the same cycle -> count stays 4 and both take effect.
  - count=0, write plus rd_tick -> count=1, data_2_valid=0.
  - count=8, write plus rd_tick -> pop occurs, write dropped, overflow=1, count=7.
- Flush: count=5, data_2_valid=1, flush plus data_1_en plus rd_tick in the same cycle -> count=0, data_2_valid=0, no write stored, data_2 unchanged.
